// File: rtl/conv_pkg.sv
// Shared types and width derivations for the convolution window controller.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IN   = 2'd1,
    ST_SYN  = 2'd2
  } win_state_e;

  typedef enum logic {
    BORDER_ZERO = 1'b0,
    BORDER_REPL = 1'b1
  } border_e;

  function automatic int calc_r(input int k);
    return (k - 1) / 2;
  endfunction

  function automatic int calc_cw(input int w_max);
    return $clog2(w_max);
  endfunction

  function automatic int calc_rw(input int h_max, input int k);
    return $clog2(h_max + k);
  endfunction

endpackage

// File: rtl/conv_win_mask.sv
// Row-valid mask for the kernel column: bit j covers image row ra-j, which is
// valid only when it lies inside 0..H-1.
module conv_win_mask #(
  parameter int K  = 5,
  parameter int RW = 11
) (
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] h,
  output logic [K-1:0]  vld
);

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      localparam logic [RW-1:0] ROW_OFS = RW'(gi);
      assign vld[gi] = (ra >= ROW_OFS) && ((ra - ROW_OFS) < h);
    end
  endgenerate

endmodule

// File: rtl/conv_win_cntrl.sv
// Window controller: sequences the K-1 line-buffer cascade and kernel column
// pushes from the pixel stream, appending R synthetic flush rows per frame.
module conv_win_cntrl
  import conv_pkg::*;
#(
  parameter int K       = 5,
  parameter int PIXEL_W = 8,
  parameter int W_MAX   = 1024,
  parameter int H_MAX   = 1024,
  localparam int R      = calc_r(K),
  localparam int CW     = calc_cw(W_MAX),
  localparam int RW     = calc_rw(H_MAX, K)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [CW:0]        cfg_w_i,
  input  logic [RW-1:0]      cfg_h_i,
  input  logic               cfg_border_i,
  input  logic               s_tvalid_i,
  output logic               s_tready_o,
  input  logic [PIXEL_W-1:0] s_tdata_i,
  input  logic               s_tuser_i,
  input  logic               s_tlast_i,
  input  logic               m_tready_i,
  output logic [K-2:0]       lb_push_o,
  output logic [K-2:0]       lb_pop_o,
  output logic               lb_eol_o,
  output logic [PIXEL_W-1:0] lb0_dat_o,
  output logic               kernel_colD_push_o,
  output logic [K-1:0]       kernel_colD_vld_o,
  output logic [RW-1:0]      kernel_pos_row_o,
  output logic [CW-1:0]      kernel_pos_col_o,
  output logic               kernel_border_o,
  output logic               frame_done_o,
  output logic               err_o
);

  win_state_e    state_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] ra_reg;
  logic [CW:0]   w_reg;
  logic [RW-1:0] h_reg;
  border_e       border_reg;
  logic          frame_done_reg;
  logic          err_reg;

  logic          idle_st;
  logic          in_st;
  logic          syn_st;
  logic          sof_acc;
  logic          in_acc;
  logic          adv;
  logic [CW:0]   w_eff;
  logic [RW-1:0] h_eff;
  logic          col_last;
  logic [RW-1:0] ra_inc;
  logic [RW-1:0] h_plus_r;

  assign idle_st = (state_reg == ST_IDLE);
  assign in_st   = (state_reg == ST_IN);
  assign syn_st  = (state_reg == ST_SYN);

  // The SOF pixel is accepted unconditionally in IDLE, so its advance cannot
  // wait on the kernel; at ra=0 it only writes the first line buffer anyway.
  assign sof_acc = idle_st & s_tvalid_i & s_tuser_i;
  assign in_acc  = in_st & s_tvalid_i & m_tready_i;
  assign adv     = sof_acc | in_acc | (syn_st & m_tready_i);

  // Geometry is not latched until the SOF edge, so the SOF cycle uses live cfg.
  assign w_eff    = idle_st ? cfg_w_i : w_reg;
  assign h_eff    = idle_st ? cfg_h_i : h_reg;
  assign col_last = ({1'b0, col_reg} == (w_eff - (CW+1)'(1)));
  assign ra_inc   = ra_reg + RW'(1);
  assign h_plus_r = h_reg + RW'(R);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg      <= ST_IDLE;
      col_reg        <= '0;
      ra_reg         <= '0;
      w_reg          <= '0;
      h_reg          <= '0;
      border_reg     <= BORDER_ZERO;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      if (sof_acc) begin
        w_reg      <= cfg_w_i;
        h_reg      <= cfg_h_i;
        border_reg <= border_e'(cfg_border_i);
        err_reg    <= (s_tlast_i != col_last);
      end else if (in_acc && (s_tuser_i || (s_tlast_i != col_last))) begin
        err_reg <= 1'b1;
      end

      if (adv) begin
        if (col_last) begin
          col_reg <= '0;
          ra_reg  <= ra_inc;
          case (state_reg)
            ST_IDLE, ST_IN: begin
              state_reg <= (ra_inc == h_eff) ? ST_SYN : ST_IN;
            end
            ST_SYN: begin
              if (ra_inc == h_plus_r) begin
                state_reg      <= ST_IDLE;
                ra_reg         <= '0;
                frame_done_reg <= 1'b1;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
              ra_reg    <= '0;
            end
          endcase
        end else begin
          col_reg <= col_reg + CW'(1);
          if (idle_st) begin
            state_reg <= ST_IN;
          end
        end
      end
    end
  end

  assign s_tready_o = idle_st | (in_st & m_tready_i);

  // Each advance shifts one column down the cascade: LBi pops once i rows are
  // buffered, and that popped pixel becomes the push into LB(i+1).
  assign lb_push_o[0] = adv;

  genvar gi;
  generate
    for (gi = 1; gi <= K-1; gi++) begin : g_pop
      assign lb_pop_o[gi-1] = adv & (ra_reg >= RW'(gi));
    end
    for (gi = 1; gi <= K-2; gi++) begin : g_push
      assign lb_push_o[gi] = lb_pop_o[gi-1];
    end
  endgenerate

  assign lb_eol_o  = adv & col_last;
  assign lb0_dat_o = syn_st ? '0 : s_tdata_i;

  assign kernel_colD_push_o = adv & (ra_reg >= RW'(R));
  assign kernel_pos_row_o   = ra_reg - RW'(R);
  assign kernel_pos_col_o   = col_reg;
  assign kernel_border_o    = border_reg;

  conv_win_mask #(
    .K  (K),
    .RW (RW)
  ) u_mask (
    .ra  (ra_reg),
    .h   (h_eff),
    .vld (kernel_colD_vld_o)
  );

  assign frame_done_o = frame_done_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_conv_win_cntrl.sv
// Scoreboard bench: per-frame expected kernel columns are queued when a frame
// is issued and popped by an independent negedge monitor.
module tb_conv_win_cntrl;

  localparam int K       = 5;
  localparam int PIXEL_W = 8;
  localparam int W_MAX   = 1024;
  localparam int H_MAX   = 1024;
  localparam int R       = (K - 1) / 2;
  localparam int CW      = $clog2(W_MAX);
  localparam int RW      = $clog2(H_MAX + K);

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic [CW:0]        cfg_w_i = '0;
  logic [RW-1:0]      cfg_h_i = '0;
  logic               cfg_border_i = 1'b0;
  logic               s_tvalid_i = 1'b0;
  logic               s_tready_o;
  logic [PIXEL_W-1:0] s_tdata_i = '0;
  logic               s_tuser_i = 1'b0;
  logic               s_tlast_i = 1'b0;
  logic               m_tready_i = 1'b0;
  logic [K-2:0]       lb_push_o;
  logic [K-2:0]       lb_pop_o;
  logic               lb_eol_o;
  logic [PIXEL_W-1:0] lb0_dat_o;
  logic               kernel_colD_push_o;
  logic [K-1:0]       kernel_colD_vld_o;
  logic [RW-1:0]      kernel_pos_row_o;
  logic [CW-1:0]      kernel_pos_col_o;
  logic               kernel_border_o;
  logic               frame_done_o;
  logic               err_o;

  always #5 clk = ~clk;

  conv_win_cntrl #(
    .K       (K),
    .PIXEL_W (PIXEL_W),
    .W_MAX   (W_MAX),
    .H_MAX   (H_MAX)
  ) dut (
    .clk                (clk),
    .arst_n             (arst_n),
    .cfg_w_i            (cfg_w_i),
    .cfg_h_i            (cfg_h_i),
    .cfg_border_i       (cfg_border_i),
    .s_tvalid_i         (s_tvalid_i),
    .s_tready_o         (s_tready_o),
    .s_tdata_i          (s_tdata_i),
    .s_tuser_i          (s_tuser_i),
    .s_tlast_i          (s_tlast_i),
    .m_tready_i         (m_tready_i),
    .lb_push_o          (lb_push_o),
    .lb_pop_o           (lb_pop_o),
    .lb_eol_o           (lb_eol_o),
    .lb0_dat_o          (lb0_dat_o),
    .kernel_colD_push_o (kernel_colD_push_o),
    .kernel_colD_vld_o  (kernel_colD_vld_o),
    .kernel_pos_row_o   (kernel_pos_row_o),
    .kernel_pos_col_o   (kernel_pos_col_o),
    .kernel_border_o    (kernel_border_o),
    .frame_done_o       (frame_done_o),
    .err_o              (err_o)
  );

  typedef struct {
    int row;
    int col;
    int vld;
    int acc_at;
    int border;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   adv_cnt = 0;
  int   first_pop1 = 0;
  int   done_seen = 0;
  int   eol_cnt = 0;
  logic tb_sof = 1'b0;
  logic mon_accept;
  exp_t mon_e;

  // Monitor: frame-relative accept/advance bookkeeping plus scoreboard pops.
  always @(negedge clk) begin
    if (arst_n) begin
      mon_accept = s_tvalid_i && s_tready_o;
      if (mon_accept) acc_cnt = tb_sof ? 1 : acc_cnt + 1;
      if (mon_accept && tb_sof) begin
        adv_cnt    = 0;
        first_pop1 = 0;
        eol_cnt    = 0;
      end
      if (lb_push_o[0]) begin
        adv_cnt++;
        if (lb_eol_o) eol_cnt++;
        checks++;
        if (mon_accept && lb0_dat_o !== s_tdata_i) begin
          errors++;
          $display("FAIL lb0_dat got %0h want %0h", lb0_dat_o, s_tdata_i);
        end else if (!mon_accept && lb0_dat_o !== '0) begin
          errors++;
          $display("FAIL lb0_dat_syn got %0h want 0", lb0_dat_o);
        end
      end
      if (lb_pop_o[1] && first_pop1 == 0) first_pop1 = adv_cnt;
      if (frame_done_o) done_seen++;
      if (kernel_colD_push_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected row %0d col %0d vld %b", kernel_pos_row_o, kernel_pos_col_o, kernel_colD_vld_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (kernel_pos_row_o !== RW'(mon_e.row) || kernel_pos_col_o !== CW'(mon_e.col) ||
              kernel_colD_vld_o !== K'(mon_e.vld) || acc_cnt != mon_e.acc_at ||
              kernel_border_o !== 1'(mon_e.border)) begin
            errors++;
            $display("FAIL kernel_push got row %0d col %0d vld %b acc %0d brd %0d want row %0d col %0d vld %b acc %0d brd %0d",
                     kernel_pos_row_o, kernel_pos_col_o, kernel_colD_vld_o, acc_cnt, kernel_border_o,
                     mon_e.row, mon_e.col, K'(mon_e.vld), mon_e.acc_at, mon_e.border);
          end else begin
            $display("push row %0d col %0d vld %b", kernel_pos_row_o, kernel_pos_col_o, kernel_colD_vld_o);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check_int({name, "_lb_push"}, int'(lb_push_o), 0);
    check_int({name, "_lb_pop"}, int'(lb_pop_o), 0);
    check_int({name, "_kpush"}, int'(kernel_colD_push_o), 0);
    check_int({name, "_done"}, int'(frame_done_o), 0);
    check_int({name, "_err"}, int'(err_o), 0);
    check_int({name, "_border"}, int'(kernel_border_o), 0);
    check_int({name, "_tready_idle"}, int'(s_tready_o), 1);
  endtask

  // Issue one frame; expectations come from the row/column geometry alone:
  // the kernel sees rows R..H+R-1 of the extended frame, one push per column.
  task automatic run_frame(input int w, input int h, input int border, input bit stall,
                           input int bad_last_p, input int bad_sof_p, input bit abort_syn);
    int  budget;
    bit  got;
    int  done_before;
    exp_t e;
    for (int ra = R; ra < h + R; ra++) begin
      for (int c = 0; c < w; c++) begin
        e.row = ra - R;
        e.col = c;
        e.vld = 0;
        for (int j = 0; j < K; j++)
          if (ra - j >= 0 && ra - j < h) e.vld |= (1 << j);
        e.acc_at = (ra * w + c + 1 < h * w) ? ra * w + c + 1 : h * w;
        e.border = border;
        exp_q.push_back(e);
      end
    end
    cfg_w_i      = (CW+1)'(w);
    cfg_h_i      = RW'(h);
    cfg_border_i = border[0];
    done_before  = done_seen;
    for (int p = 0; p < w * h; p++) begin
      s_tvalid_i = 1'b1;
      s_tdata_i  = PIXEL_W'($urandom);
      s_tuser_i  = (p == 0) || (p == bad_sof_p);
      s_tlast_i  = ((p % w) == w - 1) || (p == bad_last_p);
      tb_sof     = (p == 0);
      got        = 1'b0;
      budget     = 0;
      while (!got && budget < 200) begin
        m_tready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk);
        got = s_tready_o;
        step();
        budget++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout pixel %0d got no s_tready_o want accept", p);
      end
    end
    s_tvalid_i = 1'b0;
    s_tuser_i  = 1'b0;
    s_tlast_i  = 1'b0;
    tb_sof     = 1'b0;

    if (abort_syn) begin
      m_tready_i = 1'b1;
      step();
      step();
      arst_n     = 1'b0;
      m_tready_i = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_in_syn");
      exp_q.delete();
      step();
      arst_n = 1'b1;
      step();
      $display("frame w %0d h %0d aborted by reset", w, h);
      return;
    end

    budget = 0;
    while (done_seen == done_before && budget < 500) begin
      m_tready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      budget++;
    end
    m_tready_i = 1'b1;
    step();
    step();
    check_int("frame_done_pulses", done_seen - done_before, 1);
    check_int("pending_pushes", exp_q.size(), 0);
    check_int("adv_count", adv_cnt, w * (h + R));
    check_int("eol_count", eol_cnt, h + R);
    check_int("first_pop1_adv", first_pop1, 2 * w + 1);
    check_int("err", int'(err_o), (bad_last_p >= 0 || bad_sof_p >= 0) ? 1 : 0);
    $display("frame w %0d h %0d border %0d stall %0d advances %0d err %0d", w, h, border, stall, adv_cnt, err_o);
  endtask

  task automatic idle_junk(input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid_i = 1'b1;
      s_tuser_i  = 1'b0;
      s_tlast_i  = 1'b0;
      s_tdata_i  = PIXEL_W'($urandom);
      m_tready_i = 1'b1;
      tb_sof     = 1'b0;
      @(negedge clk);
      check_int("idle_drop_tready", int'(s_tready_o), 1);
      check_int("idle_drop_lb_push", int'(lb_push_o), 0);
      check_int("idle_drop_kpush", int'(kernel_colD_push_o), 0);
      step();
    end
    s_tvalid_i = 1'b0;
    $display("idle dropped %0d pixels", n);
  endtask

  initial begin
    arst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    step();
    arst_n = 1'b1;
    step();

    run_frame(4, 3, 0, 1'b0, -1, -1, 1'b0);
    run_frame(4, 1, 1, 1'b0, -1, -1, 1'b0);
    run_frame(8, 6, 0, 1'b1, -1, -1, 1'b0);
    run_frame(4, 3, 0, 1'b0, 2, -1, 1'b0);
    idle_junk(5);
    run_frame(4, 3, 1, 1'b0, -1, -1, 1'b0);
    run_frame(4, 3, 0, 1'b0, -1, 5, 1'b0);
    run_frame(4, 3, 1, 1'b0, -1, -1, 1'b1);
    run_frame(4, 3, 0, 1'b0, -1, -1, 1'b0);
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, 1),
                1'($urandom_range(0, 1)), -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before timeout");
    $fatal(1);
  end

endmodule
